// File: rtl/gray_ptr_ctrl.sv
// Single-clock FIFO pointer controller: binary pointers for the storage array,
// Gray-coded copies for downstream synchronisers, occupancy flags and sticky errors.
module gray_ptr_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              clr_err,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   wr_gray,
  output logic [ADDR_W:0]   rd_gray,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W:0] wr_bin_q, wr_bin_d;
  logic [ADDR_W:0] rd_bin_q, rd_bin_d;
  logic [ADDR_W:0] wr_gray_q, wr_gray_d;
  logic [ADDR_W:0] rd_gray_q, rd_gray_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  // Grants come from the registered flags, so a request is served in its own cycle.
  always_comb begin
    wr_en       = wr_req & ~full_q & ~rst;
    rd_en       = rd_req & ~empty_q & ~rst;
    wr_bin_d    = wr_bin_q + {{ADDR_W{1'b0}}, wr_en};
    rd_bin_d    = rd_bin_q + {{ADDR_W{1'b0}}, rd_en};
    wr_gray_d   = bin2gray(wr_bin_d);
    rd_gray_d   = bin2gray(rd_bin_d);
    empty_d     = (wr_gray_d == rd_gray_d);
    // Full when the two top Gray bits differ and the rest match: one lap apart.
    full_d      = (wr_gray_d == {~rd_gray_d[ADDR_W:ADDR_W-1], rd_gray_d[ADDR_W-2:0]});
    count_d     = wr_bin_d - rd_bin_d;
    overflow_d  = (wr_req & full_q) | (overflow_q & ~clr_err);
    underflow_d = (rd_req & empty_q) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bin_q    <= '0;
      rd_bin_q    <= '0;
      wr_gray_q   <= '0;
      rd_gray_q   <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_bin_q    <= wr_bin_d;
      rd_bin_q    <= rd_bin_d;
      wr_gray_q   <= wr_gray_d;
      rd_gray_q   <= rd_gray_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_addr   = wr_bin_q[ADDR_W-1:0];
  assign rd_addr   = rd_bin_q[ADDR_W-1:0];
  assign wr_gray   = wr_gray_q;
  assign rd_gray   = rd_gray_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
